// File: rtl/freq_state_detector_if.sv
// Signal bundle between the frequency detector and its consumers (LED stage, search logic).
// The detector drives the results (master); the sensor/consumer side is the slave.
interface freq_state_detector_if #(
    parameter int unsigned CNT_W = 16
);
    logic             sig_in;
    logic [3:0]       FreqState;
    logic [CNT_W-1:0] edge_count;
    logic             window_done;

    modport master (
        input  sig_in,
        output FreqState,
        output edge_count,
        output window_done
    );

    modport slave (
        output sig_in,
        input  FreqState,
        input  edge_count,
        input  window_done
    );
endinterface

// File: rtl/freq_state_detector.sv
// Counts sig_in rising edges over a fixed gate window, bins the count into a frequency code
// and publishes it as FreqState once CONFIRM consecutive windows agree.
module freq_state_detector #(
    parameter int unsigned GATE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned F9_LO       = 8,
    parameter int unsigned F9_HI       = 12,
    parameter int unsigned F10_LO      = 18,
    parameter int unsigned F10_HI      = 22,
    parameter int unsigned F11_LO      = 28,
    parameter int unsigned F11_HI      = 32,
    parameter int unsigned CONFIRM     = 3
) (
    input logic                   clk,
    input logic                   rst,
    freq_state_detector_if.master bus
);
    localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned RunW  = $clog2(CONFIRM + 1);

    localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [RunW-1:0]  RunMax   = RunW'(CONFIRM);

    logic             sync1_q, sync2_q, prev_q;
    logic             edge_det, closing;
    logic [GateW-1:0] gate_q;
    logic [CNT_W-1:0] ecnt_q, ecnt_sat, count_q;
    logic [31:0]      final_cnt;
    logic [3:0]       class_code;
    logic [3:0]       cand_q, cand_d;
    logic [RunW-1:0]  run_q, run_d;
    logic [3:0]       state_q, state_d;
    logic             done_q;

    assign edge_det  = sync2_q & ~prev_q;
    assign closing   = (gate_q == GateLast);
    // An edge seen on the closing cycle is folded into the window that is closing.
    assign ecnt_sat  = (edge_det && (ecnt_q != CntMax)) ? ecnt_q + CNT_W'(1) : ecnt_q;
    assign final_cnt = 32'(ecnt_sat);

    always_comb begin
        if (final_cnt >= F9_LO && final_cnt <= F9_HI) begin
            class_code = 4'd9;
        end else if (final_cnt >= F10_LO && final_cnt <= F10_HI) begin
            class_code = 4'd10;
        end else if (final_cnt >= F11_LO && final_cnt <= F11_HI) begin
            class_code = 4'd11;
        end else begin
            class_code = 4'd0;
        end
    end

    always_comb begin
        cand_d  = cand_q;
        run_d   = run_q;
        state_d = state_q;
        if (class_code == cand_q) begin
            if (run_q != RunMax) run_d = run_q + RunW'(1);
        end else begin
            cand_d = class_code;
            run_d  = RunW'(1);
        end
        if (run_d == RunMax) state_d = cand_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= bus.sig_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_q  <= '0;
            ecnt_q  <= '0;
            count_q <= '0;
            cand_q  <= '0;
            run_q   <= '0;
            state_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= closing;
            if (closing) begin
                gate_q  <= '0;
                ecnt_q  <= '0;
                count_q <= ecnt_sat;
                cand_q  <= cand_d;
                run_q   <= run_d;
                state_q <= state_d;
            end else begin
                gate_q <= gate_q + GateW'(1);
                ecnt_q <= ecnt_sat;
            end
        end
    end

    assign bus.FreqState   = state_q;
    assign bus.edge_count  = count_q;
    assign bus.window_done = done_q;
endmodule
